cross_bar_router_1xn: RTL

CROSS_BAR_ROUTER_1XN -- requirements
Module: cross_bar_router_1xn

---
 rtl/cross_bar_pkg.sv | 17 +
 rtl/cross_bar_skid_buffer.sv | 64 ++++++
 rtl/cross_bar_router_1xn.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cross_bar_pkg.sv
// Shared types and constants for the cross-bar router, arbiters and crossbar top.
package cross_bar_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } router_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cross_bar_skid_buffer.sv
// Two-entry input skid buffer: registered ready, one cycle from accept to out_valid,
// full throughput when the consumer pops every cycle.
module cross_bar_skid_buffer #(
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             push, pop;

  always_comb begin
    push       = in_valid & in_ready_q;
    pop        = out_ready & (count_q != 2'd0);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d    = count_q + 2'(push) - 2'(pop);
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cross_bar_router_1xn.sv
// 1-to-N AXI-Stream packet router; tdest of the first beat picks the output, out-of-range
// packets are dropped and counted. Define CROSS_BAR_ROUTER_SKID_EN to add an input skid buffer.
module cross_bar_router_1xn
  import cross_bar_pkg::*;
#(
  parameter int unsigned MSEL_WIDTH = 2,
  parameter int unsigned CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [MSEL_WIDTH-1:0] s_axis_tdest,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata [CHANNEL_NO],
  output logic [CHANNEL_NO-1:0] m_axis_tvalid,
  output logic [CHANNEL_NO-1:0] m_axis_tlast,
  input  logic [CHANNEL_NO-1:0] m_axis_tready,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned PAYLOAD_W = DATA_WIDTH + MSEL_WIDTH + 1;

  router_state_t         state_q, state_d;
  logic [MSEL_WIDTH-1:0] dest_q, dest_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic [MSEL_WIDTH-1:0] head_dest;
  logic                  pop;
  logic [CHANNEL_NO-1:0] sel_onehot;
  logic                  sel_ready;

`ifdef CROSS_BAR_ROUTER_SKID_EN
  logic [PAYLOAD_W-1:0] head_payload;

  cross_bar_skid_buffer #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (aclk),
    .rst_n    (aresetn),
    .in_valid (s_axis_tvalid),
    .in_data  ({s_axis_tdata, s_axis_tdest, s_axis_tlast}),
    .in_ready (s_axis_tready),
    .out_valid(head_valid),
    .out_data (head_payload),
    .out_ready(pop)
  );

  assign {head_data, head_dest, head_last} = head_payload;
`else
  // Head beat is the input itself; accept exactly when the head is consumed.
  assign head_valid    = s_axis_tvalid;
  assign head_data     = s_axis_tdata;
  assign head_last     = s_axis_tlast;
  assign head_dest     = s_axis_tdest;
  assign s_axis_tready = pop;
`endif

  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < CHANNEL_NO; i++) begin
      sel_onehot[i] = (dest_q == MSEL_WIDTH'(i));
    end
    sel_ready = |(sel_onehot & m_axis_tready);
  end

  // Data and tlast fan out to every channel; only tvalid carries the selection.
  always_comb begin
    for (int unsigned i = 0; i < CHANNEL_NO; i++) begin
      m_axis_tdata[i] = head_data;
    end
    m_axis_tlast = {CHANNEL_NO{head_last}};
  end

  always_comb begin
    state_d       = state_q;
    dest_d        = dest_q;
    drop_count_d  = drop_count_q;
    pop           = 1'b0;
    m_axis_tvalid = '0;
    case (state_q)
      IDLE: begin
        if (head_valid) begin
          dest_d  = head_dest;
          state_d = (32'(head_dest) < CHANNEL_NO) ? FORWARD : DROP;
        end
      end
      FORWARD: begin
        m_axis_tvalid = {CHANNEL_NO{head_valid}} & sel_onehot;
        pop           = head_valid & sel_ready;
        if (pop && head_last) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        pop = head_valid;
        if (pop && head_last) begin
          state_d      = IDLE;
          drop_count_d = sat_inc(drop_count_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;

endmodule
